// File: rtl/ram_3d_arbiter.sv
// Per-bank round-robin arbiter sharing a banked dual-port RAM among NREQ requesters.
// Up to two grants per bank per cycle (port A, then port B); reads return two cycles after grant.
module ram_3d_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned RAM_NUM = 3,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ADDR    = 12,
    localparam int unsigned BW     = (RAM_NUM > 1) ? $clog2(RAM_NUM) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          req_we_i,
    input  logic [NREQ*BW-1:0]       req_bank_i,
    input  logic [NREQ*ADDR-1:0]     req_addr_i,
    input  logic [NREQ*WIDTH-1:0]    req_wdata_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          rvalid_o,
    output logic [NREQ*WIDTH-1:0]    rdata_o,
    output logic [NREQ-1:0]          rerr_o,
    output logic [RAM_NUM-1:0]       ena_o,
    output logic [RAM_NUM-1:0]       wea_o,
    output logic [RAM_NUM-1:0]       enb_o,
    output logic [RAM_NUM-1:0]       web_o,
    output logic [RAM_NUM*ADDR-1:0]  addra_o,
    output logic [RAM_NUM*ADDR-1:0]  addrb_o,
    output logic [RAM_NUM*WIDTH-1:0] dina_o,
    output logic [RAM_NUM*WIDTH-1:0] dinb_o,
    input  logic [RAM_NUM*WIDTH-1:0] douta_i,
    input  logic [RAM_NUM*WIDTH-1:0] doutb_i
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]        rr_q    [RAM_NUM];
    logic [IW-1:0]        rr_d    [RAM_NUM];
    logic [IW-1:0]        a_idx   [RAM_NUM];
    logic [IW-1:0]        b_idx   [RAM_NUM];
    logic [RAM_NUM-1:0]   a_hit;
    logic [RAM_NUM-1:0]   b_hit;

    logic [NREQ-1:0]      bad_d;
    logic [NREQ-1:0]      err_q;
    logic [RAM_NUM-1:0]   a_rd_q;
    logic [RAM_NUM-1:0]   b_rd_q;
    logic [IW-1:0]        a_own_q [RAM_NUM];
    logic [IW-1:0]        b_own_q [RAM_NUM];

    logic [NREQ-1:0]       rvalid_d, rvalid_q;
    logic [NREQ-1:0]       rerr_q;
    logic [NREQ*WIDTH-1:0] rdata_d, rdata_q;

    // Round-robin scan per bank: first candidate takes port A, second takes port B.
    always_comb begin
        int  r;
        logic seen2;
        r     = 0;
        seen2 = 1'b0;
        for (int b = 0; b < RAM_NUM; b++) begin
            a_hit[b] = 1'b0;
            b_hit[b] = 1'b0;
            a_idx[b] = '0;
            b_idx[b] = '0;
            seen2    = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                r = (int'(rr_q[b]) + i) % NREQ;
                if (req_i[r] && int'(req_bank_i[r*BW +: BW]) == b) begin
                    if (!a_hit[b]) begin
                        a_hit[b] = 1'b1;
                        a_idx[b] = IW'(r);
                    end else if (!seen2) begin
                        seen2 = 1'b1;
                        // Two writes to one address would collide; the later one waits.
                        if (!(req_we_i[a_idx[b]] && req_we_i[r] &&
                              req_addr_i[int'(a_idx[b])*ADDR +: ADDR] ==
                              req_addr_i[r*ADDR +: ADDR])) begin
                            b_hit[b] = 1'b1;
                            b_idx[b] = IW'(r);
                        end
                    end
                end
            end
            if (b_hit[b]) begin
                rr_d[b] = IW'((int'(b_idx[b]) + 1) % NREQ);
            end else if (a_hit[b]) begin
                rr_d[b] = IW'((int'(a_idx[b]) + 1) % NREQ);
            end else begin
                rr_d[b] = rr_q[b];
            end
        end
    end

    always_comb begin
        gnt_o   = '0;
        ena_o   = '0;
        wea_o   = '0;
        enb_o   = '0;
        web_o   = '0;
        addra_o = '0;
        addrb_o = '0;
        dina_o  = '0;
        dinb_o  = '0;
        for (int r = 0; r < NREQ; r++) begin
            bad_d[r] = req_i[r] && (int'(req_bank_i[r*BW +: BW]) >= int'(RAM_NUM));
        end
        gnt_o = bad_d;
        for (int b = 0; b < RAM_NUM; b++) begin
            if (a_hit[b]) begin
                gnt_o[a_idx[b]]          = 1'b1;
                ena_o[b]                 = 1'b1;
                wea_o[b]                 = req_we_i[a_idx[b]];
                addra_o[b*ADDR +: ADDR]  = req_addr_i[int'(a_idx[b])*ADDR +: ADDR];
                dina_o[b*WIDTH +: WIDTH] = req_wdata_i[int'(a_idx[b])*WIDTH +: WIDTH];
            end
            if (b_hit[b]) begin
                gnt_o[b_idx[b]]          = 1'b1;
                enb_o[b]                 = 1'b1;
                web_o[b]                 = req_we_i[b_idx[b]];
                addrb_o[b*ADDR +: ADDR]  = req_addr_i[int'(b_idx[b])*ADDR +: ADDR];
                dinb_o[b*WIDTH +: WIDTH] = req_wdata_i[int'(b_idx[b])*WIDTH +: WIDTH];
            end
        end
        if (rst_i) begin
            gnt_o = '0;
            ena_o = '0;
            wea_o = '0;
            enb_o = '0;
            web_o = '0;
        end
    end

    // Route RAM output of the cycle after grant back to the recorded owner.
    always_comb begin
        rvalid_d = err_q;
        rdata_d  = '0;
        for (int r = 0; r < NREQ; r++) begin
            for (int b = 0; b < RAM_NUM; b++) begin
                if (a_rd_q[b] && a_own_q[b] == IW'(r)) begin
                    rvalid_d[r]               = 1'b1;
                    rdata_d[r*WIDTH +: WIDTH] = douta_i[b*WIDTH +: WIDTH];
                end
                if (b_rd_q[b] && b_own_q[b] == IW'(r)) begin
                    rvalid_d[r]               = 1'b1;
                    rdata_d[r*WIDTH +: WIDTH] = doutb_i[b*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < RAM_NUM; b++) begin
                rr_q[b]    <= '0;
                a_own_q[b] <= '0;
                b_own_q[b] <= '0;
            end
            a_rd_q   <= '0;
            b_rd_q   <= '0;
            err_q    <= '0;
            rvalid_q <= '0;
            rerr_q   <= '0;
            rdata_q  <= '0;
        end else begin
            for (int b = 0; b < RAM_NUM; b++) begin
                rr_q[b]    <= rr_d[b];
                a_own_q[b] <= a_idx[b];
                b_own_q[b] <= b_idx[b];
            end
            a_rd_q   <= ena_o & ~wea_o;
            b_rd_q   <= enb_o & ~web_o;
            err_q    <= bad_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= err_q;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rerr_o   = rerr_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_ram_3d_arbiter.sv
// Directed bench for ram_3d_arbiter: vector table plus reset-drop and fairness sequences,
// with a behavioural banked dual-port RAM (read-before-write, one-cycle latency).
module tb_ram_3d_arbiter;

    logic        clk, rst;
    logic [3:0]  req, req_we;
    logic [7:0]  req_bank;
    logic [47:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  gnt, rvalid, rerr;
    logic [63:0] rdata;
    logic [2:0]  ena, wea, enb, web;
    logic [35:0] addra, addrb;
    logic [47:0] dina, dinb, douta, doutb;

    int n_vec  = 0;
    int n_miss = 0;

    ram_3d_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .req_i(req), .req_we_i(req_we), .req_bank_i(req_bank),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .rerr_o(rerr),
        .ena_o(ena), .wea_o(wea), .enb_o(enb), .web_o(web),
        .addra_o(addra), .addrb_o(addrb), .dina_o(dina), .dinb_o(dinb),
        .douta_i(douta), .doutb_i(doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [3][4096];

    always @(posedge clk) begin
        if (rst) begin
            mem[0][12'h020] <= 16'h0A20;
            mem[0][12'h021] <= 16'h0A21;
            mem[0][12'h022] <= 16'h0A22;
            mem[1][12'h005] <= 16'hBEEF;
            mem[1][12'h007] <= 16'h0001;
            mem[2][12'h030] <= 16'h2C00;
            mem[2][12'h031] <= 16'h2C01;
            mem[2][12'h032] <= 16'h2C02;
            mem[2][12'h033] <= 16'h2C03;
        end else begin
            for (int b = 0; b < 3; b++) begin
                if (ena[b]) begin
                    if (wea[b]) mem[b][addra[b*12 +: 12]] <= dina[b*16 +: 16];
                    douta[b*16 +: 16] <= mem[b][addra[b*12 +: 12]];
                end
                if (enb[b]) begin
                    if (web[b]) mem[b][addrb[b*12 +: 12]] <= dinb[b*16 +: 16];
                    doutb[b*16 +: 16] <= mem[b][addrb[b*12 +: 12]];
                end
            end
        end
    end

    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  we;
        logic [7:0]  bank;
        logic [47:0] addr;
        logic [63:0] wdata;
        logic [3:0]  gnt;
        logic [2:0]  ena;
        logic [2:0]  wea;
        logic [2:0]  enb;
        logic [2:0]  web;
        logic [3:0]  rv;
        logic [3:0]  re;
        logic [63:0] rd;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(logic [3:0] rq, logic [3:0] we, logic [7:0] bk,
                                logic [47:0] ad, logic [63:0] wd, logic [3:0] g,
                                logic [2:0] ea, logic [2:0] wa, logic [2:0] eb,
                                logic [2:0] wb, logic [3:0] rv, logic [3:0] re,
                                logic [63:0] rd);
        vec_t v;
        v = '{req: rq, we: we, bank: bk, addr: ad, wdata: wd, gnt: g, ena: ea, wea: wa,
              enb: eb, web: wb, rv: rv, re: re, rd: rd};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] rq, input logic [3:0] we, input logic [7:0] bk,
                         input logic [47:0] ad, input logic [63:0] wd);
        req       = rq;
        req_we    = we;
        req_bank  = bk;
        req_addr  = ad;
        req_wdata = wd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int cnt [4];
    logic [3:0] eg;
    logic [3:0] erv;

    initial begin
        // Vector table: each entry is one cycle; rv/re/rd describe the registered outputs
        // visible during that cycle (i.e. from the grant two entries earlier).
        vecs[0]  = mk(4'b0001, 4'b0000, 8'b00_00_00_01, 48'h000_000_000_005, 64'h0,
                      4'b0001, 3'b010, 3'b000, 3'b000, 3'b000, 4'b0000, 4'b0000, 64'h0);
        vecs[1]  = mk(4'b1010, 4'b1010, 8'b00_00_00_00, 48'h010_000_010_000,
                      64'h2222_0000_1111_0000,
                      4'b0010, 3'b001, 3'b001, 3'b000, 3'b000, 4'b0000, 4'b0000, 64'h0);
        vecs[2]  = mk(4'b1000, 4'b1000, 8'b00_00_00_00, 48'h010_000_010_000,
                      64'h2222_0000_1111_0000,
                      4'b1000, 3'b001, 3'b001, 3'b000, 3'b000, 4'b0001, 4'b0000,
                      64'h0000_0000_0000_BEEF);
        vecs[3]  = mk(4'b1000, 4'b0000, 8'b00_00_00_00, 48'h010_000_000_000, 64'h0,
                      4'b1000, 3'b001, 3'b000, 3'b000, 3'b000, 4'b0000, 4'b0000, 64'h0);
        vecs[4]  = mk(4'b0111, 4'b0000, 8'b00_00_00_00, 48'h000_022_021_020, 64'h0,
                      4'b0011, 3'b001, 3'b000, 3'b001, 3'b000, 4'b0000, 4'b0000, 64'h0);
        vecs[5]  = mk(4'b0100, 4'b0000, 8'b00_00_00_00, 48'h000_022_021_020, 64'h0,
                      4'b0100, 3'b001, 3'b000, 3'b000, 3'b000, 4'b1000, 4'b0000,
                      64'h2222_0000_0000_0000);
        vecs[6]  = mk(4'b0011, 4'b0001, 8'b00_00_01_01, 48'h000_000_007_007,
                      64'h0000_0000_0000_AAAA,
                      4'b0011, 3'b010, 3'b000, 3'b010, 3'b010, 4'b0011, 4'b0000,
                      64'h0000_0000_0A21_0A20);
        vecs[7]  = mk(4'b0100, 4'b0000, 8'b00_01_00_00, 48'h000_007_000_000, 64'h0,
                      4'b0100, 3'b010, 3'b000, 3'b000, 3'b000, 4'b0100, 4'b0000,
                      64'h0000_0A22_0000_0000);
        vecs[8]  = mk(4'b0100, 4'b0000, 8'b00_11_00_00, 48'h000_055_000_000, 64'h0,
                      4'b0100, 3'b000, 3'b000, 3'b000, 3'b000, 4'b0010, 4'b0000,
                      64'h0000_0000_0001_0000);
        vecs[9]  = mk(4'b0000, 4'b0000, 8'h00, 48'h0, 64'h0,
                      4'b0000, 3'b000, 3'b000, 3'b000, 3'b000, 4'b0100, 4'b0000,
                      64'h0000_AAAA_0000_0000);
        vecs[10] = mk(4'b0000, 4'b0000, 8'h00, 48'h0, 64'h0,
                      4'b0000, 3'b000, 3'b000, 3'b000, 3'b000, 4'b0100, 4'b0100, 64'h0);
        vecs[11] = mk(4'b1001, 4'b1000, 8'b11_00_00_10, 48'h033_000_000_030,
                      64'h5555_0000_0000_0000,
                      4'b1001, 3'b100, 3'b000, 3'b000, 3'b000, 4'b0000, 4'b0000, 64'h0);
        vecs[12] = mk(4'b0000, 4'b0000, 8'h00, 48'h0, 64'h0,
                      4'b0000, 3'b000, 3'b000, 3'b000, 3'b000, 4'b0000, 4'b0000, 64'h0);
        vecs[13] = mk(4'b0000, 4'b0000, 8'h00, 48'h0, 64'h0,
                      4'b0000, 3'b000, 3'b000, 3'b000, 3'b000, 4'b1001, 4'b1000,
                      64'h0000_0000_0000_2C00);

        rst = 1'b1;
        drive(4'b0, 4'b0, 8'h0, 48'h0, 64'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset rvalid", {60'h0, rvalid}, 64'h0);
        chk("reset rerr", {60'h0, rerr}, 64'h0);
        chk("reset rdata", rdata, 64'h0);
        next_cycle();

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].req, vecs[i].we, vecs[i].bank, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            chk($sformatf("v%0d gnt", i), {60'h0, gnt}, {60'h0, vecs[i].gnt});
            chk($sformatf("v%0d ena", i), {61'h0, ena}, {61'h0, vecs[i].ena});
            chk($sformatf("v%0d enb", i), {61'h0, enb}, {61'h0, vecs[i].enb});
            chk($sformatf("v%0d wea", i), {61'h0, wea & vecs[i].ena}, {61'h0, vecs[i].wea});
            chk($sformatf("v%0d web", i), {61'h0, web & vecs[i].enb}, {61'h0, vecs[i].web});
            chk($sformatf("v%0d rvalid", i), {60'h0, rvalid}, {60'h0, vecs[i].rv});
            chk($sformatf("v%0d rerr", i), {60'h0, rerr}, {60'h0, vecs[i].re});
            for (int r = 0; r < 4; r++) begin
                if (vecs[i].rv[r])
                    chk($sformatf("v%0d rdata[%0d]", i, r), {48'h0, rdata[r*16 +: 16]},
                        {48'h0, vecs[i].rd[r*16 +: 16]});
            end
            next_cycle();
        end

        // Read granted, then reset right after the RAM edge: no rvalid may follow.
        drive(4'b0001, 4'b0000, 8'b00_00_00_01, 48'h000_000_000_005, 64'h0);
        @(negedge clk);
        chk("rst seq gnt", {60'h0, gnt}, 64'h1);
        chk("rst seq ena", {61'h0, ena}, 64'h2);
        chk("rst seq addra", {52'h0, addra[12 +: 12]}, 64'h005);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("in reset gnt", {60'h0, gnt}, 64'h0);
        chk("in reset ena", {61'h0, ena | enb}, 64'h0);
        chk("in reset rvalid", {60'h0, rvalid}, 64'h0);
        next_cycle();
        rst = 1'b0;
        drive(4'b0, 4'b0, 8'h0, 48'h0, 64'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post reset rvalid c%0d", c), {60'h0, rvalid}, 64'h0);
            next_cycle();
        end

        // Fairness: four requesters hammer bank 2; pairs alternate every cycle.
        for (int r = 0; r < 4; r++) cnt[r] = 0;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) drive(4'b1111, 4'b0000, 8'b10_10_10_10, 48'h033_032_031_030, 64'h0);
            else       drive(4'b0, 4'b0, 8'h0, 48'h0, 64'h0);
            @(negedge clk);
            if (c < 8) begin
                eg = (c % 2 == 0) ? 4'b0011 : 4'b1100;
                chk($sformatf("fair gnt c%0d", c), {60'h0, gnt}, {60'h0, eg});
                for (int r = 0; r < 4; r++) cnt[r] += int'(gnt[r]);
            end
            if (c >= 2) erv = ((c - 2) % 2 == 0) ? 4'b0011 : 4'b1100;
            else        erv = 4'b0000;
            chk($sformatf("fair rvalid c%0d", c), {60'h0, rvalid}, {60'h0, erv});
            for (int r = 0; r < 4; r++) begin
                if (erv[r])
                    chk($sformatf("fair rdata[%0d] c%0d", r, c), {48'h0, rdata[r*16 +: 16]},
                        {48'h0, 16'h2C00 + 16'(r)});
            end
            next_cycle();
        end
        for (int r = 0; r < 4; r++)
            chk($sformatf("fair count[%0d]", r), 64'(cnt[r]), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ram_3d_arbiter.md
# ram_3d_arbiter

Per-bank round-robin arbiter that shares a banked dual-port RAM array (RAM_NUM independent banks, each with ports A and B) among NREQ requesters. Each cycle, for every bank, it grants up to two requesters targeting that bank: the first in round-robin order gets port A, the second gets port B. It drives the RAM enables, write enables, addresses and write data, then routes each read result back to its requester with a registered valid strobe. It sits between compute engines and the banked RAM.

## Interface
- NREQ, 4, number of requesters
- RAM_NUM, 3, number of RAM banks
- WIDTH, 16, data width
- ADDR, 12, per-bank address width
- BW, $clog2(RAM_NUM) (minimum 1), bank-select width (derived localparam)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  request, held until granted
- req_we  in  NREQ  1 = write, 0 = read
- req_bank  in  NREQ*BW  target bank, packed; requester r uses [r*BW +: BW]
- req_addr  in  NREQ*ADDR  word address, packed
- req_wdata  in  NREQ*WIDTH  write data, packed
- gnt  out  NREQ  combinational grant; the access is issued this cycle
- rvalid  out  NREQ  registered read-data strobe; also pulses for erroneous requests
- rdata  out  NREQ*WIDTH  registered read data, packed
- rerr  out  NREQ  registered; high with rvalid when req_bank ≥ RAM_NUM
- ena, wea, enb, web  out  RAM_NUM  per-bank port enables and write enables
- addra, addrb  out  RAM_NUM*ADDR  per-bank port addresses, packed
- dina, dinb  out  RAM_NUM*WIDTH  per-bank write data, packed
- douta, doutb  in  RAM_NUM*WIDTH  RAM read data, valid the cycle after the enable

## Operation
- Each bank b keeps a round-robin pointer rr[b] (requester index); it resets to 0.
- Candidates for bank b are requesters r with req[r]=1 and req_bank[r]=b. Scan starts at rr[b] and wraps modulo NREQ.
  - First candidate found gets port A: ena[b]=1, wea[b]=req_we, addra/dina taken from that requester.
  - Second candidate found gets port B, with the same rules on enb/web/addrb/dinb.
- Write-write hazard: if both candidates are writes to the same address, port B is not granted. The second candidate waits.
- A read and a write to the same address on the two ports of a bank are both granted. The read returns the pre-write value.
- rr[b] updates to (index of last granted requester on b)+1 mod NREQ. It is unchanged if nothing was granted on b.
- A request with req_bank ≥ RAM_NUM is granted immediately and drives no RAM port. Two cycles later it produces rvalid=1, rerr=1 and rdata=0, whether it was a read or a write.
- Writes produce no rvalid.
- Per bank, the arbiter records the port A and port B owner plus a read flag in a one-stage pipeline register (owner/read-flag register).

## Timing
- Grant cycle T: gnt, RAM enables, address and data are all combinational from req and rr.
- Edge T+1: the RAM latches data. douta/doutb are valid during cycle T+1.
- Edge T+2: rdata[r] and rvalid[r] are registered from the recorded port. Read latency from grant to rvalid is 2 cycles.
- A requester that is granted at T may issue a new request at T+1. Back-to-back reads give one rvalid per cycle.
- Reset values:
  - rvalid=0, rerr=0, rdata=0, rr=0, owner/read-flag register cleared.
  - While rst=1, gnt and all RAM enables are forced to 0.
- Reset asserted mid-operation: in-flight reads are dropped, and no rvalid is produced for them after reset releases.
- Requesters must hold req, req_we, req_bank, req_addr and req_wdata stable until gnt.

## Test plan
- Single read: r0 reads bank 1, addr 0x005, which holds 0xBEEF → gnt[0] at T, enb[1]=0, ena[1]=1, addra=0x005; at T+2 rvalid[0]=1, rdata=0xBEEF.
- Three-way contention: r0, r1 and r2 all read bank 0 with rr=0 → cycle 1 grants r0 (port A) and r1 (port B). Cycle 2 grants r2 on port A (rr=2). Each rvalid arrives 2 cycles after its grant with the correct data.
- Fairness: all 4 requesters continuously read bank 2 for 8 cycles → each is granted exactly 4 times, and no requester waits more than 1 cycle.
- Write-write hazard: r1 and r3 both write bank 0, addr 0x010, with 0x1111 and 0x2222 → only r1 is granted in cycle 1 and r3 in cycle 2. A subsequent read returns 0x2222.
- Read-during-write: r0 writes 0xAAAA to bank 1, addr 7 (old value 0x0001) while r1 reads bank 1, addr 7 in the same cycle → r1 gets rdata=0x0001. A later read returns 0xAAAA.
- Bad bank and reset: r2 requests bank 3 with RAM_NUM=3 → immediate gnt, no RAM enable, and at T+2 rvalid=1, rerr=1, rdata=0. Separately, asserting rst at T+1 after a read grant → no rvalid ever appears for that read.
